// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch stage and its prefetch queue:
//   - NOP encoding presented to decode when no instruction is available,
//     together with the condition/body constants decode uses for it
//   - fetch state machine encoding
//   - prefetch queue entry layout {pc, instr}
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

   // ARM condition field "always" and the architectural NOP body.
   localparam logic [3:0]  COND_AL   = 4'hE;
   localparam logic [27:0] NOP_BODY  = 28'h320_F000;
   localparam logic [31:0] NOP_INSTR = {COND_AL, NOP_BODY};  // 32'hE320F000

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,  // request at fetch_pc outstanding
      ST_WAIT    = 2'd1,  // queue full, no request
      ST_DISCARD = 2'd2   // request at stale_pc outstanding, response dropped
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of {pc, instr} entries between instruction memory and
// decode. The head is read combinationally from registered storage so a word
// pushed at edge N is visible in cycle N+1.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : drop the head entry
//   flush       : empty the queue (overrides push and pop)
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
//   head        : entry at the head (meaningful only when !empty)
// ---------------------------------------------------------------------------
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] head_reg;
   logic [AW-1:0] tail_reg;
   logic [CW-1:0] count_reg;

   // Pointers are AW bits wide, so DEPTH being a power of two makes the
   // natural binary overflow the modulo-DEPTH wrap.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (pop) begin
            head_reg <= head_reg + 1'b1;
         end
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // Storage carries no reset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_reg[tail_reg] <= push_entry;
      end
   end

   assign head  = mem_reg[head_reg];
   assign count = count_reg;
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage feeding decode. Holds the fetch PC, issues word requests to
// instruction memory under a req/ack handshake, buffers returned words in a
// prefetch queue and presents the head to decode. A branch redirect flushes
// the queue; a request already in flight at that moment is completed and its
// data dropped (DISCARD) so the memory handshake is never broken.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   stall_i        : decode not accepting, head held
//   branch_i       : redirect request
//   branch_addr_i  : redirect target, bits [1:0] ignored
//   imem_req_o     : memory request
//   imem_addr_o    : word-aligned request address
//   imem_ack_i     : request complete, imem_data_i valid this cycle
//   imem_data_i    : fetched word
//   instr_o        : head instruction, NOP when empty
//   instr_valid_o  : head valid
//   pc_o           : address of instr_o, 0 when empty
// ---------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic [31:0] pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_reg;
   fetch_state_e  state_next;
   logic [31:0]   fetch_pc_reg;
   logic [31:0]   fetch_pc_next;
   logic [31:0]   stale_pc_reg;
   logic [31:0]   stale_pc_next;

   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_head;
   fetch_entry_t  push_entry;
   logic          push;
   logic          pop;
   logic          flush;
   logic [CW-1:0] count_n;
   logic [31:0]   target;
   logic          unused_addr_bits;

   assign target           = {branch_addr_i[31:2], 2'b00};
   assign unused_addr_bits = ^branch_addr_i[1:0];

   // Branch has priority: it suppresses both push and pop and flushes.
   assign flush = branch_i;
   assign pop   = !q_empty && !stall_i && !branch_i;
   // The FSM never sits in FETCH with a full queue; the !q_full term only
   // guards the storage should that ever be violated.
   assign push  = (state_reg == ST_FETCH) && imem_ack_i && !branch_i && !q_full;

   assign push_entry.pc    = fetch_pc_reg;
   assign push_entry.instr = imem_data_i;

   // Occupancy after this edge, used to decide FETCH -> WAIT.
   assign count_n = q_count + CW'(push) - CW'(pop);

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count),
      .head       (q_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_FETCH;
         fetch_pc_reg <= RESET_PC;
         stale_pc_reg <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         stale_pc_reg <= stale_pc_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      stale_pc_next = stale_pc_reg;
      case (state_reg)
         ST_FETCH: begin
            if (branch_i) begin
               fetch_pc_next = target;
               // Without an ack the request at fetch_pc is still in flight:
               // keep presenting it until it completes, then drop the data.
               if (!imem_ack_i) begin
                  stale_pc_next = fetch_pc_reg;
                  state_next    = ST_DISCARD;
               end
            end else if (imem_ack_i) begin
               fetch_pc_next = fetch_pc_reg + 32'd4;
               if (count_n == CW'(DEPTH)) begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (branch_i) begin
               fetch_pc_next = target;
               state_next    = ST_FETCH;
            end else if (pop) begin
               state_next = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (branch_i) begin
               fetch_pc_next = target;
            end
            if (imem_ack_i) begin
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // Request is dropped while rst is high so a reset abandons any request.
   assign imem_req_o  = !rst && ((state_reg == ST_FETCH) || (state_reg == ST_DISCARD));
   assign imem_addr_o = (state_reg == ST_DISCARD) ? stale_pc_reg : fetch_pc_reg;

   assign instr_valid_o = !q_empty;
   assign instr_o       = q_empty ? NOP_INSTR : q_head.instr;
   assign pc_o          = q_empty ? 32'h0000_0000 : q_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Table of directed cycle vectors, a hand-written slow-memory/branch sequence,
// then randomized traffic checked against a queue-level reference model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'hE320_F000;
   localparam int          NVEC     = 27;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic [31:0] pc_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instruction_fetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .pc_o          (pc_o)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic        ack;
      logic        branch;
      logic [31:0] baddr;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   vec_t vecs [NVEC];

   // Reference model state: what decode should see and what is in flight.
   ent_t        mq[$];
   logic [31:0] m_next_pc;
   logic [31:0] m_stale_pc;
   bit          m_discard;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic vec_t mk(input logic r, input logic s, input logic a,
                               input logic b, input logic [31:0] ba,
                               input logic q, input logic [31:0] ad,
                               input logic v, input logic [31:0] p);
      vec_t t;
      t.rst = r; t.stall = s; t.ack = a; t.branch = b; t.baddr = ba;
      t.req = q; t.addr = ad; t.valid = v; t.pc = p;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic exp_req,
                                input logic [31:0] exp_addr, input logic exp_valid,
                                input logic [31:0] exp_pc, input logic [31:0] exp_instr);
      chk({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, exp_req});
      if (exp_req) begin
         chk({tag, ".addr"}, imem_addr_o, exp_addr);
      end
      chk({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, exp_valid});
      chk({tag, ".pc"}, pc_o, exp_pc);
      chk({tag, ".instr"}, instr_o, exp_instr);
   endtask

   // Drive one cycle of inputs (memory returns the word at the current
   // address), then sample 1 time unit after the rising edge.
   task automatic cyc(input logic r, input logic s, input logic a,
                      input logic b, input logic [31:0] ba);
      rst           = r;
      stall_i       = s;
      imem_ack_i    = a;
      branch_i      = b;
      branch_addr_i = ba;
      imem_data_i   = mem_word(imem_addr_o);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_next_pc  = RESET_PC;
      m_stale_pc = '0;
      m_discard  = 0;
   endtask

   initial begin
      int          wcnt;
      int          lat;
      logic        exp_req;
      logic        acc;
      logic        do_pop;
      logic [31:0] exp_addr;
      logic [31:0] ins;

      rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
      imem_ack_i = 1'b0; imem_data_i = '0;

      // ---------------- directed vectors ----------------
      //            rst stall ack br  baddr          req addr           valid pc
      vecs[0]  = mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
      vecs[1]  = mk(0, 1, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0);
      vecs[2]  = mk(0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0);
      vecs[3]  = mk(0, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h0);
      vecs[4]  = mk(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h0);
      vecs[5]  = mk(0, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0);
      vecs[6]  = mk(0, 0, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4);
      vecs[7]  = mk(0, 1, 1, 0, 32'h0,          0, 32'h14,         1, 32'h4);
      vecs[8]  = mk(0, 0, 0, 0, 32'h0,          1, 32'h14,         1, 32'h8);
      vecs[9]  = mk(0, 0, 1, 0, 32'h0,          1, 32'h18,         1, 32'hC);
      vecs[10] = mk(0, 0, 1, 0, 32'h0,          1, 32'h1C,         1, 32'h10);
      vecs[11] = mk(0, 0, 1, 1, 32'h203,        1, 32'h200,        0, 32'h0);
      vecs[12] = mk(0, 0, 1, 0, 32'h0,          1, 32'h204,        1, 32'h200);
      vecs[13] = mk(0, 0, 0, 0, 32'h0,          1, 32'h204,        0, 32'h0);
      vecs[14] = mk(0, 0, 0, 1, 32'h100,        1, 32'h204,        0, 32'h0);
      vecs[15] = mk(0, 0, 0, 0, 32'h0,          1, 32'h204,        0, 32'h0);
      vecs[16] = mk(0, 0, 1, 0, 32'h0,          1, 32'h100,        0, 32'h0);
      vecs[17] = mk(0, 1, 1, 0, 32'h0,          1, 32'h104,        1, 32'h100);
      vecs[18] = mk(0, 1, 1, 0, 32'h0,          1, 32'h108,        1, 32'h100);
      vecs[19] = mk(0, 1, 1, 0, 32'h0,          1, 32'h10C,        1, 32'h100);
      vecs[20] = mk(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
      vecs[21] = mk(0, 0, 0, 0, 32'h0,          1, RESET_PC,       0, 32'h0);
      vecs[22] = mk(0, 0, 1, 1, 32'hFFFF_FFFE,  1, 32'hFFFF_FFFC,  0, 32'h0);
      vecs[23] = mk(0, 0, 1, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC);
      vecs[24] = mk(0, 0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0);
      vecs[25] = mk(0, 0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4);
      vecs[26] = mk(0, 0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h8);

      for (int i = 0; i < NVEC; i++) begin
         cyc(vecs[i].rst, vecs[i].stall, vecs[i].ack, vecs[i].branch, vecs[i].baddr);
         ins = vecs[i].valid ? mem_word(vecs[i].pc) : NOP;
         check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                       vecs[i].valid, vecs[i].pc, ins);
         $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h instr=%h",
                  i, imem_req_o, imem_addr_o, instr_valid_o, pc_o, instr_o);
      end

      // ------- slow memory, branch while the request waits for ack -------
      cyc(1, 0, 0, 0, 32'h0);
      check_outputs("slow.rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      cyc(0, 0, 0, 0, 32'h0);
      check_outputs("slow.w1", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      cyc(0, 0, 0, 1, 32'h100);
      check_outputs("slow.w2br", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      cyc(0, 0, 0, 0, 32'h0);
      check_outputs("slow.w3", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      cyc(0, 0, 1, 0, 32'h0);
      check_outputs("slow.stale_ack", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
      cyc(0, 0, 1, 0, 32'h0);
      check_outputs("slow.first", 1'b1, 32'h104, 1'b1, 32'h100, mem_word(32'h100));
      $display("slow-memory branch sequence: first pc=%h", pc_o);

      // ---------------- randomized traffic vs model ----------------
      cyc(1, 0, 0, 0, 32'h0);
      model_reset();
      wcnt = 0;
      lat  = $urandom_range(0, 3);
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         stall_i  = ($urandom_range(0, 9) < 4);
         branch_i = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            branch_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         end else begin
            branch_addr_i = 32'($urandom_range(0, 32'hFFFF));
         end
         #1;
         exp_req     = !rst && (mq.size() < DEPTH);
         imem_ack_i  = imem_req_o && (wcnt >= lat);
         imem_data_i = mem_word(imem_addr_o);
         #1;
         exp_addr = m_discard ? m_stale_pc : m_next_pc;
         if (mq.size() > 0) begin
            check_outputs($sformatf("rnd%0d", c), exp_req, exp_addr, 1'b1,
                          mq[0].pc, mq[0].instr);
         end else begin
            check_outputs($sformatf("rnd%0d", c), exp_req, exp_addr, 1'b0,
                          32'h0, NOP);
         end

         if (rst) begin
            model_reset();
         end else begin
            acc    = imem_ack_i && exp_req;
            do_pop = (mq.size() > 0) && !stall_i && !branch_i;
            if (branch_i) begin
               mq.delete();
               if (acc) begin
                  m_discard = 0;
               end else if (exp_req && !m_discard) begin
                  m_discard  = 1;
                  m_stale_pc = m_next_pc;
               end
               m_next_pc = {branch_addr_i[31:2], 2'b00};
               $display("rnd %0d: redirect to %h", c, m_next_pc);
            end else begin
               if (do_pop) begin
                  void'(mq.pop_front());
               end
               if (acc) begin
                  if (m_discard) begin
                     m_discard = 0;
                  end else begin
                     mq.push_back('{pc: m_next_pc, instr: mem_word(m_next_pc)});
                     m_next_pc = m_next_pc + 32'd4;
                  end
               end
            end
         end

         if (rst || !imem_req_o) begin
            wcnt = 0;
         end else if (imem_ack_i) begin
            wcnt = 0;
            lat  = $urandom_range(0, 3);
         end else begin
            wcnt++;
         end

         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of instruction decode. It holds the fetch PC and issues word requests to instruction memory under a req/ack handshake. Returned words are buffered in a small prefetch queue, and the queue head is presented to decode as `instr_o`/`pc_o`. Branch redirects from downstream flush the queue, and any in-flight stale response is discarded.

## Interface
Parameters:
- `DEPTH`, default 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word aligned.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall_i`, in, 1: decode not accepting; the head is held.
- `branch_i`, in, 1: redirect request from downstream.
- `branch_addr_i`, in, 32: redirect target; bits [1:0] ignored.
- `imem_req_o`, out, 1: memory request.
- `imem_addr_o`, out, 32: request address, word aligned.
- `imem_ack_i`, in, 1: request complete; `imem_data_i` is valid in the same cycle.
- `imem_data_i`, in, 32: fetched word.
- `instr_o`, out, 32: head instruction, or NOP (32'hE320F000, AL + NOP) when the queue is empty.
- `instr_valid_o`, out, 1: the queue head is valid.
- `pc_o`, out, 32: address of `instr_o`; 0 when the queue is empty.

## Operation
State machine (`imem_req_o`/`imem_addr_o` decode from registered state):
- FETCH: req=1, addr=`fetch_pc`.
- WAIT: req=0; the queue is full.
- DISCARD: req=1, addr=`stale_pc`; the eventual response is dropped.

Transitions, where `count_n` is the post-edge occupancy:
- FETCH, ack, no branch:
  - push {`fetch_pc`, data}; `fetch_pc` += 4, wrapping mod 2^32.
  - go to WAIT if `count_n`==DEPTH, else stay in FETCH.
- FETCH, branch, ack in the same cycle: data dropped, queue flushed, `fetch_pc`=target, stay in FETCH.
- FETCH, branch, no ack: queue flushed, `stale_pc`=`fetch_pc`, `fetch_pc`=target, go to DISCARD.
- DISCARD, ack: data dropped, go to FETCH. A branch in the same cycle updates `fetch_pc` only.
- DISCARD, branch, no ack: `fetch_pc`=latest target, stay in DISCARD. The queue is already empty.
- WAIT, pop or branch: go to FETCH. A branch flushes the queue and loads `fetch_pc`.

Queue and handshake rules:
- Pop occurs when `instr_valid_o` && !`stall_i` && !`branch_i`.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Push never occurs when full: FETCH is never entered with `count`==DEPTH.
- Handshake: `imem_addr_o` is stable while req=1 and ack=0. The memory may take any number of cycles to ack.

Branch rules:
- `branch_i` has priority over push and pop.
- A flush zeroes `count`, head and tail.

Reset values (while `rst`=1 and after):
- state=FETCH, `fetch_pc`=RESET_PC, `count`=0.
- `imem_req_o`=0 during the reset cycle, 1 from the first cycle after.
- `instr_valid_o`=0, `instr_o`=32'hE320F000, `pc_o`=0.
- Reset mid-request abandons the request. Memory must tolerate req dropping without an ack.

## Timing
- Ack at edge N: the entry is visible on `instr_o` after edge N, i.e. in cycle N+1.
- With a zero-wait memory (ack in the same cycle as req), sustained throughput is 1 word/cycle.
- Branch at edge N: `instr_valid_o`=0 in cycle N+1. A request for the target is issued in cycle N+1 (from FETCH) or the cycle after the stale ack (from DISCARD).
- WAIT→FETCH: req rises the cycle after the pop edge.
- Outputs `instr_o`, `pc_o`, `instr_valid_o` are combinational from registered queue state only. There is no path from `stall_i` or `branch_i` to these outputs.

## Structure
- Shared package holds:
  - `NOP_INSTR` (32'hE320F000), alongside the existing NOP/AL condition constants used by decode.
  - fetch state encoding.
- Sub-module `fetch_queue`: synchronous FIFO of {pc[31:0], instr[31:0]}.
  - Ports: push, pop, flush, full, empty, count, head.
  - Pointers wrap modulo DEPTH.
- The FSM, PC and handshake logic sit in the top module.

## Test plan
- Reset release, zero-wait memory acking every cycle, no stall:
  - `imem_addr_o` sequence 0,4,8,…
  - `pc_o`/`instr_o` follow one cycle behind, `instr_valid_o` continuously 1.
- `stall_i`=1 held:
  - DEPTH=4 words are accepted, then req=0 (WAIT).
  - Releasing the stall for 1 cycle pops pc 0; req returns the next cycle at addr 16.
- Memory acks 3 cycles after req; `branch_i` at 0x100 in the second wait cycle:
  - addr stays at the old value until ack, and that data is never output.
  - The next request is at 0x100; `pc_o`=0x100 is the first valid output.
- `branch_i`=1 with ack in the same cycle:
  - the acked word is dropped and the queue is empty next cycle.
  - `branch_addr_i`=0x203 gives fetch addr 0x200.
- `fetch_pc`=32'hFFFF_FFFC: the following fetch is at 32'h0000_0000.
- Assert `rst` with the queue holding 3 entries and a pending request:
  - next cycle `instr_valid_o`=0, `instr_o`=32'hE320F000, `pc_o`=0.
  - the first post-reset request is at RESET_PC.
